// File: rtl/uart_pkg.sv
// uart_pkg: shared UART link types and constants for uart_tx and uart_rx
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter pulsing bit_done on its last count, optionally at half a bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit HALF_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_done
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LAST = HALF_BIT ? CLKS_PER_BIT / 2 - 1 : CLKS_PER_BIT - 1;
  logic [W-1:0] cnt;
  assign bit_done = en && cnt == W'(LAST);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= bit_done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, registered 8-bit frame out with optional even parity and 1 or 2 stop bits
import uart_pkg::*;
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx,
  output logic                      busy
);
  uart_tx_state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] data_q;
  logic [2:0] idx_q, idx_d;
  logic par_q, stop_q, stop_d, tx_d, bit_done;
  assign tx_ready = state_q == IDLE;
  assign busy = !tx_ready;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .HALF_BIT(1'b0)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .en(busy),
    .clr(tx_ready),
    .bit_done(bit_done)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      stop_q <= 1'b0;
      tx <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      stop_q <= stop_d;
      tx <= tx_d;
      if (tx_ready && tx_valid) begin
        data_q <= tx_data;
        par_q <= ^tx_data;
      end
    end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    stop_d = stop_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        stop_d = 1'b0;
        if (tx_valid) state_d = START;
      end
      START: if (bit_done) state_d = DATA;
      DATA: if (bit_done) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_done) state_d = STOP;
      STOP: if (bit_done) begin
        stop_d = !stop_q;
        if (STOP_BITS == 1 || stop_q) begin
          state_d = IDLE;
          stop_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? data_q[idx_d] : state_d == PARITY ? par_q : 1'b1;
  end
endmodule
